// File: rtl/cnn_pe_controller.sv
// cnn_pe_controller
//   Sequencing FSM for the CNN processing-element datapath. It waits for
//   IFmap/filter scratch-pad data, issues fetch/multiply/accumulate strobes
//   for each MAC, closes every filter window through the result buffer, and
//   advances filter, stride and start pointer.
//
// Optional feature macro: PE_CTRL_PERF_EN adds the mac_count and
// stall_cycles performance counters.
//
// Ports
//   clk                 in   rising-edge clock
//   rst                 in   asynchronous active-low reset
//   start               in   level; begin/continue processing while high
//   sp_valid, filter_cannot_read, go_next_stride, stride_ended,
//   is_last_filter, error                      in   datapath status
//   stall[1:0]          in   result-buffer write stall (0 = no stall)
//   en_p_traverse, ren, ld_IF, mult_en, i_en, ld_result, first_time
//                       out  MAC-path strobes
//   done, next_filter, next_psum_addr          out  window-close strobes
//   next_stride, rst_current_filter, rst_is_last_filter
//                       out  window-advance strobes
//   next_start, rst_stride, rst_stride_ended, rst_p_valid, make_empty
//                       out  row-advance strobes
//   busy                out  FSM not in IDLE/ERR
//   err                 out  sticky error flag
//   err_code[1:0]       out  01 datapath error, 10 timeout, 00 none
//   mac_count, stall_cycles  out  saturating counters (PE_CTRL_PERF_EN only)
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// WAIT  | waiting for scratch-pad data; timeout counter running
// FETCH | read scratch pads, load IFmap register
// MULT  | multiply; first_time marks the first MAC of a filter window
// ACC   | accumulate into result; decide window close
// CLOSE | hold done while result buffer stalls, then write psum
// ADV   | last filter done: advance stride, reset filter pointers
// ROW   | stride row ended: advance start pointer, empty buffers
// ERR   | sticky error, only reset leaves it

module cnn_pe_controller #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_WIDTH       = 10,
  parameter int PERF_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sp_valid,
  input  logic       filter_cannot_read,
  input  logic       go_next_stride,
  input  logic       stride_ended,
  input  logic       is_last_filter,
  input  logic       error,
  input  logic [1:0] stall,
  output logic       en_p_traverse,
  output logic       ren,
  output logic       ld_IF,
  output logic       mult_en,
  output logic       i_en,
  output logic       ld_result,
  output logic       first_time,
  output logic       done,
  output logic       next_filter,
  output logic       next_psum_addr,
  output logic       next_stride,
  output logic       rst_current_filter,
  output logic       rst_is_last_filter,
  output logic       next_start,
  output logic       rst_stride,
  output logic       rst_stride_ended,
  output logic       rst_p_valid,
  output logic       make_empty,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] mac_count,
  output logic [PERF_WIDTH-1:0] stall_cycles
`endif
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WAIT  = 4'd1,
    S_FETCH = 4'd2,
    S_MULT  = 4'd3,
    S_ACC   = 4'd4,
    S_CLOSE = 4'd5,
    S_ADV   = 4'd6,
    S_ROW   = 4'd7,
    S_ERR   = 4'd8
  } state_t;

  // Elaboration-time sanity checks on the parameter set.
  if (TO_WIDTH < $clog2(TIMEOUT_CYCLES + 1)) begin : g_to_width_chk
    $error("TO_WIDTH too small for TIMEOUT_CYCLES");
  end
  if (PERF_WIDTH < 1) begin : g_perf_width_chk
    $error("PERF_WIDTH must be at least 1");
  end

  state_t              state;
  state_t              state_next;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                first_flag;
  logic                data_ready;
  logic                to_hit;
  logic                stall_active;

  assign data_ready   = sp_valid & ~filter_cannot_read;
  // The counter holds the number of earlier non-ready WAIT cycles, so the
  // TIMEOUT_CYCLES-th consecutive non-ready cycle is the one that trips.
  assign to_hit       = (to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign stall_active = (stall != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next         = state;
    en_p_traverse      = 1'b0;
    ren                = 1'b0;
    ld_IF              = 1'b0;
    mult_en            = 1'b0;
    i_en               = 1'b0;
    ld_result          = 1'b0;
    first_time         = 1'b0;
    done               = 1'b0;
    next_filter        = 1'b0;
    next_psum_addr     = 1'b0;
    next_stride        = 1'b0;
    rst_current_filter = 1'b0;
    rst_is_last_filter = 1'b0;
    next_start         = 1'b0;
    rst_stride         = 1'b0;
    rst_stride_ended   = 1'b0;
    rst_p_valid        = 1'b0;
    make_empty         = 1'b0;
    busy               = 1'b1;
    err                = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_WAIT;
      end
      S_WAIT: begin
        en_p_traverse = 1'b1;
        // A datapath error wins over data arriving in the same cycle.
        if (error)           state_next = S_ERR;
        else if (data_ready) state_next = S_FETCH;
        else if (to_hit)     state_next = S_ERR;
      end
      S_FETCH: begin
        ren        = 1'b1;
        ld_IF      = 1'b1;
        state_next = S_MULT;
      end
      S_MULT: begin
        mult_en    = 1'b1;
        first_time = first_flag;
        state_next = S_ACC;
      end
      S_ACC: begin
        ld_result  = 1'b1;
        i_en       = 1'b1;
        state_next = go_next_stride ? S_CLOSE : S_WAIT;
      end
      S_CLOSE: begin
        // done covers the whole close, including the final write cycle.
        done = 1'b1;
        if (!stall_active) begin
          next_psum_addr = 1'b1;
          if (is_last_filter) begin
            state_next = S_ADV;
          end else begin
            next_filter = 1'b1;
            state_next  = S_WAIT;
          end
        end
      end
      S_ADV: begin
        next_stride        = 1'b1;
        rst_current_filter = 1'b1;
        rst_is_last_filter = 1'b1;
        state_next         = stride_ended ? S_ROW : S_WAIT;
      end
      S_ROW: begin
        next_start       = 1'b1;
        rst_stride       = 1'b1;
        rst_stride_ended = 1'b1;
        rst_p_valid      = 1'b1;
        make_empty       = 1'b1;
        state_next       = start ? S_WAIT : S_IDLE;
      end
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == S_WAIT && state_next == S_WAIT) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  // first_flag marks that the next MULT opens a new filter window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_flag <= 1'b1;
    end else begin
      case (state)
        S_ACC:   first_flag <= 1'b0;
        S_CLOSE: if (!stall_active && !is_last_filter) first_flag <= 1'b1;
        S_ADV:   first_flag <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_code <= 2'b00;
    end else if (state == S_WAIT && state_next == S_ERR) begin
      err_code <= error ? 2'b01 : 2'b10;
    end
  end

`ifdef PE_CTRL_PERF_EN
  logic stall_inc;

  assign stall_inc = (state == S_WAIT) || (state == S_CLOSE && stall_active);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (state == S_ACC && mac_count != '1) begin
        mac_count <= mac_count + 1'b1;
      end
      if (stall_inc && stall_cycles != '1) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end
`endif

endmodule
